// File: rtl/pontos_flutuantes.sv
// Multi-cycle adder for a custom float {sign, EXP_W-bit exponent (bias 2**(EXP_W-1)-1), FRAC_W-bit fraction}.
// A free-running FSM captures, aligns, adds, normalizes, rounds and publishes one sum per pass.
module pontos_flutuantes #(
  parameter int EXP_W  = 6,
  parameter int FRAC_W = 25
) (
  input  logic                        clock_100kHz,
  input  logic                        reset,
  input  logic [EXP_W+FRAC_W:0]       op_A_in,
  input  logic [EXP_W+FRAC_W:0]       op_B_in,
  output logic [EXP_W+FRAC_W:0]       data_out,
  output logic [3:0]                  status_out,
  output logic [2:0]                  qual_lugar
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  // Working mantissa: {hidden, fraction, guard, round}; sticky is kept separately.
  localparam int MW = FRAC_W + 3;

  localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   ONE_E    = (EXP_W+1)'(1);
  localparam logic [EXP_W:0]   TWO_E    = (EXP_W+1)'(2);
  localparam logic [EXP_W-1:0] DIFF_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] DIFF_LIM = EXP_W'(MW);

  typedef enum logic [2:0] {
    LOAD      = 3'd0,
    ALIGN     = 3'd1,
    ADD       = 3'd2,
    NORMALIZE = 3'd3,
    ROUND     = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [MW-1:0]     mant_a_q, mant_a_d;
  logic [MW-1:0]     mant_b_q, mant_b_d;
  logic              sticky_q, sticky_d;
  logic [EXP_W-1:0]  diff_q, diff_d;
  logic [MW:0]       sum_q, sum_d;
  logic              ovf_in_q, ovf_in_d;
  logic              zero_q, zero_d;
  logic [W-1:0]      data_q, data_d;
  logic [3:0]        status_q, status_d;

  logic [EXP_W-1:0]  ea_s, eb_s;
  logic [MW-1:0]     ma_s, mb_s;
  logic [W-2:0]      mag_a_s, mag_b_s;
  logic              a_ge_s;
  logic              inexact_s, rup_s, hid_s;
  logic [MW-2:0]     rnd_s;
  logic [FRAC_W-1:0] frac_s;
  logic [EXP_W:0]    exp_r_s;

  assign ea_s    = op_A_in[W-2:FRAC_W];
  assign eb_s    = op_B_in[W-2:FRAC_W];
  assign ma_s    = (ea_s == '0) ? '0 : {1'b1, op_A_in[FRAC_W-1:0], 2'b00};
  assign mb_s    = (eb_s == '0) ? '0 : {1'b1, op_B_in[FRAC_W-1:0], 2'b00};
  assign mag_a_s = (ea_s == '0) ? '0 : op_A_in[W-2:0];
  assign mag_b_s = (eb_s == '0) ? '0 : op_B_in[W-2:0];
  assign a_ge_s  = (mag_a_s >= mag_b_s);

  // Round-to-nearest-even on guard/round/sticky; rnd_s top bit flags a mantissa carry-out.
  assign inexact_s = sum_q[1] | sum_q[0] | sticky_q;
  assign rup_s     = sum_q[1] & (sum_q[0] | sticky_q | sum_q[2]);
  assign rnd_s     = {1'b0, sum_q[MW-1:2]} + {{(MW-2){1'b0}}, rup_s};
  assign hid_s     = rnd_s[FRAC_W+1] | rnd_s[FRAC_W];
  assign frac_s    = rnd_s[FRAC_W+1] ? rnd_s[FRAC_W:1] : rnd_s[FRAC_W-1:0];
  assign exp_r_s   = exp_q + {{EXP_W{1'b0}}, rnd_s[FRAC_W+1]};

  always_comb begin
    state_d  = state_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    exp_d    = exp_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    sticky_d = sticky_q;
    diff_d   = diff_q;
    sum_d    = sum_q;
    ovf_in_d = ovf_in_q;
    zero_d   = zero_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      LOAD: begin
        if (a_ge_s) begin
          sign_a_d = op_A_in[W-1];
          sign_b_d = op_B_in[W-1];
          exp_d    = {1'b0, ea_s};
          mant_a_d = ma_s;
          mant_b_d = mb_s;
          diff_d   = ea_s - eb_s;
        end else begin
          sign_a_d = op_B_in[W-1];
          sign_b_d = op_A_in[W-1];
          exp_d    = {1'b0, eb_s};
          mant_a_d = mb_s;
          mant_b_d = ma_s;
          diff_d   = eb_s - ea_s;
        end
        sticky_d = 1'b0;
        zero_d   = 1'b0;
        ovf_in_d = (&ea_s) | (&eb_s);
        state_d  = ALIGN;
      end
      ALIGN: begin
        if (diff_q > DIFF_LIM) begin
          mant_b_d = '0;
          sticky_d = sticky_q | (|mant_b_q);
          diff_d   = '0;
          state_d  = ADD;
        end else if (diff_q == '0) begin
          state_d = ADD;
        end else begin
          mant_b_d = mant_b_q >> 1;
          sticky_d = sticky_q | mant_b_q[0];
          diff_d   = diff_q - DIFF_ONE;
          if (diff_q == DIFF_ONE) begin
            state_d = ADD;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ADD: begin
        // Sticky acts as a borrow on subtraction so the truncated difference stays a floor.
        if (sign_a_q == sign_b_q) begin
          sum_d = {1'b0, mant_a_q} + {1'b0, mant_b_q};
        end else begin
          sum_d = {1'b0, mant_a_q} - {1'b0, mant_b_q} - {{MW{1'b0}}, sticky_q};
        end
        state_d = NORMALIZE;
      end
      NORMALIZE: begin
        if (sum_q[MW]) begin
          sum_d    = sum_q >> 1;
          sticky_d = sticky_q | sum_q[0];
          exp_d    = exp_q + ONE_E;
          state_d  = ROUND;
        end else if (sum_q == '0) begin
          zero_d  = 1'b1;
          state_d = ROUND;
        end else if (!sum_q[MW-1] && (exp_q > ONE_E)) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - ONE_E;
          if (sum_q[MW-2] || (exp_q == TWO_E)) begin
            state_d = ROUND;
          end else begin
            state_d = NORMALIZE;
          end
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (ovf_in_q || (exp_r_s >= EXP_MAX)) begin
          data_d   = {sign_a_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          status_d = 4'b0100;
        end else if (zero_q) begin
          data_d   = '0;
          status_d = 4'b1000;
        end else if (!hid_s) begin
          data_d   = {sign_a_q, {(W-1){1'b0}}};
          status_d = 4'b0010;
        end else begin
          data_d   = {sign_a_q, exp_r_s[EXP_W-1:0], frac_s};
          status_d = inexact_s ? 4'b0001 : 4'b1000;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock_100kHz) begin
    if (!reset) begin
      state_q  <= LOAD;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_q    <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      sticky_q <= 1'b0;
      diff_q   <= '0;
      sum_q    <= '0;
      ovf_in_q <= 1'b0;
      zero_q   <= 1'b0;
      data_q   <= '0;
      status_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_q    <= exp_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      sticky_q <= sticky_d;
      diff_q   <= diff_d;
      sum_q    <= sum_d;
      ovf_in_q <= ovf_in_d;
      zero_q   <= zero_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign data_out   = data_q;
  assign status_out = status_q;
  assign qual_lugar = state_q;

endmodule

// File: tb/tb_pontos_flutuantes.sv
// Scoreboard bench for pontos_flutuantes: the driver queues hand-computed results as it
// presents operands, and a monitor checks each published sum when the FSM sits in DONE.
module tb_pontos_flutuantes;

  logic        clk;
  logic        reset;
  logic [31:0] op_a, op_b;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic [2:0]  qual_lugar;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pontos_flutuantes dut (
    .clock_100kHz (clk),
    .reset        (reset),
    .op_A_in      (op_a),
    .op_B_in      (op_b),
    .data_out     (data_out),
    .status_out   (status_out),
    .qual_lugar   (qual_lugar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int NV = 12;
  logic [31:0] va [NV] = '{32'h3E000000, 32'h3E000000, 32'h7DFFFFFF, 32'h3E000000,
                           32'h83000000, 32'h00000000, 32'h3E000000, 32'h40000000,
                           32'h3E000001, 32'h3E000000, 32'hBE000000, 32'h3E000000};
  logic [31:0] vb [NV] = '{32'h40000000, 32'hBE000000, 32'h7DFFFFFF, 32'h0A000000,
                           32'h02000000, 32'h00000000, 32'h7E000000, 32'hBE000000,
                           32'h0A000000, 32'h02000000, 32'hC0000000, 32'h88000000};
  logic [31:0] vr [NV] = '{32'h41000000, 32'h00000000, 32'h7E000000, 32'h3E000000,
                           32'h80000000, 32'h00000000, 32'h7E000000, 32'h3E000000,
                           32'h3E000002, 32'h3E000000, 32'hC1000000, 32'h3E000000};
  logic [3:0]  vs [NV] = '{4'b1000, 4'b1000, 4'b0100, 4'b0001,
                           4'b0010, 4'b1000, 4'b0100, 4'b1000,
                           4'b0001, 4'b0001, 4'b1000, 4'b0001};
  logic [2:0]  seq [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic finish_bench();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic drive(input int k, input bit push);
    exp_t e;
    op_a = va[k];
    op_b = vb[k];
    if (push) begin
      e.data = vr[k];
      e.status = vs[k];
      e.id = k;
      sb.push_back(e);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (qual_lugar == st) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout waiting for state %0d", st);
    finish_bench();
  endtask

  // Monitor: every published result is matched against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && qual_lugar === 3'd5) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h required=none", data_out);
      end else begin
        e = sb.pop_front();
        chk($sformatf("data_v%0d", e.id), data_out, e.data);
        chk($sformatf("status_v%0d", e.id), {28'd0, status_out}, {28'd0, e.status});
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive(0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_data", data_out, 32'h0);
    chk("reset_status", {28'd0, status_out}, 32'h0);
    chk("reset_state", {29'd0, qual_lugar}, 32'h0);

    drive(0, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("seq_%0d", i), {29'd0, qual_lugar}, {29'd0, seq[i]});
      if (i == 4) drive(1, 1'b1);
    end

    for (int k = 2; k < NV; k++) begin
      wait_state(3'd5, 100);
      drive(k, 1'b1);
    end
    wait_state(3'd5, 100);

    // Abort a long alignment (diff 26) with a reset pulse, then let it restart cleanly.
    drive(3, 1'b0);
    wait_state(3'd1, 20);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_data", data_out, 32'h0);
    chk("abort_status", {28'd0, status_out}, 32'h0);
    chk("abort_state", {29'd0, qual_lugar}, 32'h0);
    drive(3, 1'b1);
    reset = 1'b1;
    wait_state(3'd5, 100);
    @(negedge clk);
    chk("queue_drained", sb.size(), 32'd0);
    finish_bench();
  end

endmodule
